// File: rtl/uart_instr_assembler_pkg.sv
// Shared ISA definitions for the UART instruction assembler: instruction
// layout, opcode set, assembler FSM states and default timeout.
package uart_instr_assembler_pkg;

    localparam int INSTR_BYTES          = 4;
    localparam int UART_TIMEOUT_DEFAULT = 100000;

    typedef enum logic [7:0] {
        OP_NOP   = 8'h00,
        OP_ADD   = 8'h01,
        OP_SUB   = 8'h02,
        OP_AND   = 8'h03,
        OP_OR    = 8'h04,
        OP_XOR   = 8'h05,
        OP_LOAD  = 8'h06,
        OP_STORE = 8'h07,
        OP_JUMP  = 8'h08,
        OP_BEQ   = 8'h09,
        OP_HALT  = 8'hFF
    } opcode_e;

    typedef struct packed {
        logic [8:0] empty;
        logic [4:0] src2;
        logic [4:0] src1;
        logic [4:0] dest;
        opcode_e    opcode;
    } yongatek_instruction_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } asm_state_e;

    // True when the opcode byte is one of the defined opcode_e members.
    function automatic logic is_legal_opcode(input logic [7:0] op);
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_LOAD, OP_STORE, OP_JUMP, OP_BEQ, OP_HALT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_instr_assembler_fifo.sv
// instr_fifo: parameterised synchronous show-ahead FIFO with occupancy count.
// A push while full succeeds only when a pop happens in the same cycle.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    // Next pointer, count and storage values for this cycle's push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_instr_assembler.sv
// uart_instr_assembler: packs UART bytes (little-endian) into 32-bit
// instructions and buffers them in instr_fifo for the processor.
// Optional macro OPCODE_FILTER_EN drops words with an unknown opcode or a
// non-zero empty field and adds the sticky illegal_instr output.
module uart_instr_assembler
    import uart_instr_assembler_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = UART_TIMEOUT_DEFAULT,
    parameter int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output yongatek_instruction_t instr_out,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  overflow,
    output logic                  timeout_err
`ifdef OPCODE_FILTER_EN
    ,
    output logic                  illegal_instr
`endif
);

    localparam int               WORD_W    = INSTR_BYTES * 8;
    localparam int               TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       BYTE_LAST = 2'(INSTR_BYTES - 1);

    asm_state_e        state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              overflow_q, overflow_d;
    logic              timeout_q, timeout_d;
    logic              word_legal;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_data;

`ifdef OPCODE_FILTER_EN
    yongatek_instruction_t word_view;
    logic                  illegal_q, illegal_d;

    assign word_view     = yongatek_instruction_t'(word_q);
    assign word_legal    = is_legal_opcode(word_view.opcode) && (word_view.empty == '0);
    assign illegal_instr = illegal_q;
`else
    assign word_legal    = 1'b1;
`endif

    assign instr_valid = !fifo_empty;
    assign fifo_pop    = instr_valid && instr_ready;
    assign instr_out   = yongatek_instruction_t'(fifo_data);
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (word_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Assembler FSM: byte collection, idle timeout and commit into the FIFO.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        to_cnt_d   = '0;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        fifo_push  = 1'b0;
`ifdef OPCODE_FILTER_EN
        illegal_d  = illegal_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    word_d[7:0] = rx_data;
                    byte_cnt_d  = 2'd1;
                    state_d     = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (rx_valid) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    if (byte_cnt_q == BYTE_LAST) begin
                        byte_cnt_d = 2'd0;
                        state_d    = ST_COMMIT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    byte_cnt_d = 2'd0;
                    timeout_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_COMMIT: begin
                if (!word_legal) begin
`ifdef OPCODE_FILTER_EN
                    illegal_d = 1'b1;
`endif
                end else if (fifo_full && !fifo_pop) begin
                    overflow_d = 1'b1;
                end else begin
                    fifo_push = 1'b1;
                end
                if (rx_valid) begin
                    word_d[7:0] = rx_data;
                    byte_cnt_d  = 2'd1;
                    state_d     = ST_COLLECT;
                end else begin
                    byte_cnt_d  = 2'd0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                byte_cnt_d = 2'd0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State, assembly and sticky-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            word_q     <= '0;
            to_cnt_q   <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef OPCODE_FILTER_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            to_cnt_q   <= to_cnt_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
`ifdef OPCODE_FILTER_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

endmodule
